sram_port_arbiter: RTL and testbench



---
 rtl/sram_port_arbiter_pkg.sv | 32 +++
 rtl/sram_port_arbiter_order_fifo.sv | 75 +++++++
 rtl/sram_port_arbiter.sv | 120 ++++++++++++
 tb/tb_sram_port_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// sram_port_arbiter_pkg
// Shared definitions for the instruction/data SRAM port arbiter.
//   SRC_INST / SRC_DATA : source IDs stored in the order FIFO
//   SIZE_BYTE/HALF/WORD : SRAM-like transfer size encodings
//   clog2()             : pointer width helper for the order FIFO
// -----------------------------------------------------------------------------
package sram_port_arbiter_pkg;

    // Source ID recorded for every accepted request
    localparam logic SRC_INST = 1'b0;
    localparam logic SRC_DATA = 1'b1;

    // SRAM-like transfer size encodings
    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Ceiling log2 used to size FIFO pointers; bounded loop keeps it
    // usable as a constant function during elaboration
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/sram_port_arbiter_order_fifo.sv
// -----------------------------------------------------------------------------
// order_fifo
// One-bit-wide synchronous FIFO remembering which port issued each accepted
// request, so responses returned in order can be routed back.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   push, din  : enqueue a source ID (ignored when full)
//   pop        : dequeue the head entry (ignored when empty)
//   full/empty : occupancy flags
//   head       : source ID at the front of the queue
// -----------------------------------------------------------------------------
module order_fifo
    import sram_port_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic din,
    input  logic pop,
    output logic full,
    output logic empty,
    output logic head
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [DEPTH-1:0] mem;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    // Entry storage needs no reset: an empty count means nothing is read
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; the count cannot
    // exceed DEPTH because pushes are refused when full
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// -----------------------------------------------------------------------------
// sram_port_arbiter
// Merges the core's instruction and data SRAM-like ports into one master port
// for the AXI bridge, and routes in-order responses back to the issuing port.
// Ports:
//   aclk, aresetn         : clock, asynchronous active-low reset
//   inst_* / data_*       : SRAM-like slave ports from the core
//   m_*                   : merged SRAM-like master port to the bridge
// Parameter:
//   MAX_OUTSTANDING       : order FIFO depth (power of two, >= 2)
// Build option:
//   ARB_ROUND_ROBIN_EN    : when defined, ties alternate between the ports;
//                           otherwise data always beats inst.
// -----------------------------------------------------------------------------
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    input  logic        inst_uncached,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    input  logic        data_uncached,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        m_req,
    output logic        m_wr,
    output logic [1:0]  m_size,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic        m_uncached,
    input  logic [31:0] m_rdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok
);

    logic sel;
    logic sel_req;
    logic accept;
    logic resp;
    logic fifo_full;
    logic fifo_empty;
    logic fifo_head;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_grant;

    // On a tie the port that did not win last time goes first; last_grant
    // resets to inst so data wins the first tie
    always_comb begin
        sel = SRC_INST;
        if (inst_req && data_req) begin
            sel = (last_grant == SRC_DATA) ? SRC_INST : SRC_DATA;
        end else if (data_req) begin
            sel = SRC_DATA;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            last_grant <= SRC_INST;
        end else if (accept) begin
            last_grant <= sel;
        end
    end
`else
    // Fixed priority: data accesses stall the pipeline longer, so they win
    always_comb begin
        sel = data_req ? SRC_DATA : SRC_INST;
    end
`endif

    // Request mux; a full FIFO blocks forwarding even if it pops this cycle
    assign sel_req    = (sel == SRC_DATA) ? data_req      : inst_req;
    assign m_wr       = (sel == SRC_DATA) ? data_wr       : inst_wr;
    assign m_size     = (sel == SRC_DATA) ? data_size     : inst_size;
    assign m_addr     = (sel == SRC_DATA) ? data_addr     : inst_addr;
    assign m_wdata    = (sel == SRC_DATA) ? data_wdata    : inst_wdata;
    assign m_uncached = (sel == SRC_DATA) ? data_uncached : inst_uncached;
    assign m_req      = sel_req & ~fifo_full & aresetn;

    assign accept       = m_req & m_addr_ok;
    assign inst_addr_ok = accept & (sel == SRC_INST);
    assign data_addr_ok = accept & (sel == SRC_DATA);

    // Responses with nothing outstanding are silently dropped
    assign resp         = m_data_ok & ~fifo_empty & aresetn;
    assign inst_data_ok = resp & (fifo_head == SRC_INST);
    assign data_data_ok = resp & (fifo_head == SRC_DATA);
    assign inst_rdata   = m_rdata;
    assign data_rdata   = m_rdata;

    order_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_order_fifo (
        .clk   (aclk),
        .rst_n (aresetn),
        .push  (accept),
        .din   (sel),
        .pop   (resp),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

endmodule

// File: tb/tb_sram_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_port_arbiter
// Directed testbench for sram_port_arbiter (MAX_OUTSTANDING = 4). Honours
// ARB_ROUND_ROBIN_EN for the tie-sequence expectations.
// -----------------------------------------------------------------------------
module tb_sram_port_arbiter;
    import sram_port_arbiter_pkg::*;

    logic        aclk;
    logic        aresetn;
    logic        inst_req, inst_wr, inst_uncached;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_wdata;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr, data_uncached;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        m_req, m_wr, m_uncached;
    logic [1:0]  m_size;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic        m_addr_ok, m_data_ok;

    int checks;
    int errors;

    sram_port_arbiter #(.MAX_OUTSTANDING(4)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .inst_req      (inst_req),
        .inst_wr       (inst_wr),
        .inst_size     (inst_size),
        .inst_addr     (inst_addr),
        .inst_wdata    (inst_wdata),
        .inst_uncached (inst_uncached),
        .inst_addr_ok  (inst_addr_ok),
        .inst_data_ok  (inst_data_ok),
        .inst_rdata    (inst_rdata),
        .data_req      (data_req),
        .data_wr       (data_wr),
        .data_size     (data_size),
        .data_addr     (data_addr),
        .data_wdata    (data_wdata),
        .data_uncached (data_uncached),
        .data_addr_ok  (data_addr_ok),
        .data_data_ok  (data_data_ok),
        .data_rdata    (data_rdata),
        .m_req         (m_req),
        .m_wr          (m_wr),
        .m_size        (m_size),
        .m_addr        (m_addr),
        .m_wdata       (m_wdata),
        .m_uncached    (m_uncached),
        .m_rdata       (m_rdata),
        .m_addr_ok     (m_addr_ok),
        .m_data_ok     (m_data_ok)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic idle_inputs();
        inst_req = 1'b0; inst_wr = 1'b0; inst_size = SIZE_WORD;
        inst_addr = 32'h0; inst_wdata = 32'h0; inst_uncached = 1'b0;
        data_req = 1'b0; data_wr = 1'b0; data_size = SIZE_WORD;
        data_addr = 32'h0; data_wdata = 32'h0; data_uncached = 1'b0;
        m_addr_ok = 1'b0; m_data_ok = 1'b0; m_rdata = 32'h0;
    endtask

    task automatic test_reset();
        idle_inputs();
        aresetn = 1'b0;
        inst_req = 1'b1; inst_addr = 32'hBFC00000; inst_size = SIZE_HALF;
        m_addr_ok = 1'b1; m_data_ok = 1'b1; m_rdata = 32'hDEADBEEF;
        #2;
        checks++; if (m_req !== 1'b0) begin errors++; $display("[TB] FAIL reset m_req got %b exp 0", m_req); end
        checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b00) begin errors++; $display("[TB] FAIL reset addr_ok got %b exp 00", {inst_addr_ok, data_addr_ok}); end
        checks++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin errors++; $display("[TB] FAIL reset data_ok got %b exp 00", {inst_data_ok, data_data_ok}); end
        checks++; if (inst_rdata !== 32'hDEADBEEF || data_rdata !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL reset rdata got %h/%h exp deadbeef", inst_rdata, data_rdata); end
        checks++; if (m_addr !== 32'hBFC00000 || m_size !== SIZE_HALF) begin errors++; $display("[TB] FAIL reset mux got %h/%0d exp bfc00000/1", m_addr, m_size); end
        tick();
        tick();
        idle_inputs();
        aresetn = 1'b1;
        tick();
    endtask

    task automatic test_inst_read();
        inst_req = 1'b1; inst_addr = 32'hBFC00000; inst_size = SIZE_WORD; m_addr_ok = 1'b1;
        #1;
        checks++; if (m_req !== 1'b1 || m_addr !== 32'hBFC00000 || m_wr !== 1'b0 || m_size !== SIZE_WORD) begin errors++; $display("[TB] FAIL inst_rd fwd got req=%b addr=%h wr=%b size=%0d exp 1/bfc00000/0/2", m_req, m_addr, m_wr, m_size); end
        checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b10) begin errors++; $display("[TB] FAIL inst_rd addr_ok got %b exp 10", {inst_addr_ok, data_addr_ok}); end
        tick();
        idle_inputs();
        m_data_ok = 1'b1; m_rdata = 32'h3C080001;
        #1;
        checks++; if ({inst_data_ok, data_data_ok} !== 2'b10) begin errors++; $display("[TB] FAIL inst_rd data_ok got %b exp 10", {inst_data_ok, data_data_ok}); end
        checks++; if (inst_rdata !== 32'h3C080001) begin errors++; $display("[TB] FAIL inst_rd rdata got %h exp 3c080001", inst_rdata); end
        tick();
        idle_inputs();
    endtask

    task automatic test_tie_priority();
        inst_req = 1'b1; inst_addr = 32'hBFC00004;
        data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h80001000; data_wdata = 32'h12345678;
        data_uncached = 1'b1;
        m_addr_ok = 1'b1;
        #1;
        checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b01) begin errors++; $display("[TB] FAIL tie grant1 got %b exp 01", {inst_addr_ok, data_addr_ok}); end
        checks++; if (m_addr !== 32'h80001000 || m_wdata !== 32'h12345678 || m_wr !== 1'b1 || m_uncached !== 1'b1) begin errors++; $display("[TB] FAIL tie fwd1 got %h/%h/%b/%b exp 80001000/12345678/1/1", m_addr, m_wdata, m_wr, m_uncached); end
        tick();
        data_req = 1'b0;
        #1;
        checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b10 || m_addr !== 32'hBFC00004 || m_uncached !== 1'b0) begin errors++; $display("[TB] FAIL tie grant2 got %b addr=%h unc=%b exp 10/bfc00004/0", {inst_addr_ok, data_addr_ok}, m_addr, m_uncached); end
        tick();
        idle_inputs();
        m_data_ok = 1'b1; m_rdata = 32'h11111111;
        #1;
        checks++; if ({inst_data_ok, data_data_ok} !== 2'b01 || data_rdata !== 32'h11111111) begin errors++; $display("[TB] FAIL tie resp1 got %b/%h exp 01/11111111", {inst_data_ok, data_data_ok}, data_rdata); end
        tick();
        m_rdata = 32'h22222222;
        #1;
        checks++; if ({inst_data_ok, data_data_ok} !== 2'b10 || inst_rdata !== 32'h22222222) begin errors++; $display("[TB] FAIL tie resp2 got %b/%h exp 10/22222222", {inst_data_ok, data_data_ok}, inst_rdata); end
        tick();
        idle_inputs();
    endtask

    // Four consecutive ties; the previous accept went to inst
    task automatic test_tie_sequence();
        logic exp_data [4];
`ifdef ARB_ROUND_ROBIN_EN
        exp_data = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_data = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        for (int i = 0; i < 4; i++) begin
            inst_req = 1'b1; inst_addr = 32'hBFC00100 + 32'(i * 4);
            data_req = 1'b1; data_addr = 32'h80002000 + 32'(i * 4);
            m_addr_ok = 1'b1;
            #1;
            checks++; if (data_addr_ok !== exp_data[i] || inst_addr_ok !== ~exp_data[i]) begin errors++; $display("[TB] FAIL seq grant%0d got i=%b d=%b exp d=%b", i, inst_addr_ok, data_addr_ok, exp_data[i]); end
            checks++; if (m_addr !== (exp_data[i] ? 32'h80002000 + 32'(i * 4) : 32'hBFC00100 + 32'(i * 4))) begin errors++; $display("[TB] FAIL seq addr%0d got %h", i, m_addr); end
            tick();
        end
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            m_data_ok = 1'b1; m_rdata = 32'h100 + 32'(i);
            #1;
            checks++; if (data_data_ok !== exp_data[i] || inst_data_ok !== ~exp_data[i]) begin errors++; $display("[TB] FAIL seq resp%0d got i=%b d=%b exp d=%b", i, inst_data_ok, data_data_ok, exp_data[i]); end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_fifo_full();
        for (int i = 0; i < 4; i++) begin
            inst_req = 1'b1; inst_addr = 32'hBFC00200 + 32'(i * 4); m_addr_ok = 1'b1;
            #1;
            checks++; if (inst_addr_ok !== 1'b1) begin errors++; $display("[TB] FAIL full fill%0d addr_ok got %b exp 1", i, inst_addr_ok); end
            tick();
        end
        m_data_ok = 1'b1; m_rdata = 32'h0000F00D;
        #1;
        checks++; if (m_req !== 1'b0 || inst_addr_ok !== 1'b0) begin errors++; $display("[TB] FAIL full block got m_req=%b addr_ok=%b exp 0/0", m_req, inst_addr_ok); end
        checks++; if (inst_data_ok !== 1'b1) begin errors++; $display("[TB] FAIL full pop got %b exp 1", inst_data_ok); end
        tick();
        m_data_ok = 1'b0;
        #1;
        checks++; if (m_req !== 1'b1 || inst_addr_ok !== 1'b1) begin errors++; $display("[TB] FAIL full retry got m_req=%b addr_ok=%b exp 1/1", m_req, inst_addr_ok); end
        tick();
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            m_data_ok = 1'b1;
            #1;
            checks++; if (inst_data_ok !== 1'b1) begin errors++; $display("[TB] FAIL full drain%0d got %b exp 1", i, inst_data_ok); end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_interleaved();
        logic        src_data [3];
        logic [31:0] vals [3];
        src_data = '{1'b0, 1'b1, 1'b0};
        vals     = '{32'hA, 32'hB, 32'hC};
        for (int i = 0; i < 3; i++) begin
            inst_req = ~src_data[i]; data_req = src_data[i]; m_addr_ok = 1'b1;
            inst_addr = 32'hBFC00300; data_addr = 32'h80003000;
            #1;
            checks++; if ({inst_addr_ok, data_addr_ok} !== {~src_data[i], src_data[i]}) begin errors++; $display("[TB] FAIL ilv issue%0d got %b", i, {inst_addr_ok, data_addr_ok}); end
            tick();
        end
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            m_data_ok = 1'b1; m_rdata = vals[i];
            #1;
            checks++; if ({inst_data_ok, data_data_ok} !== {~src_data[i], src_data[i]}) begin errors++; $display("[TB] FAIL ilv route%0d got %b", i, {inst_data_ok, data_data_ok}); end
            checks++; if ((src_data[i] ? data_rdata : inst_rdata) !== vals[i]) begin errors++; $display("[TB] FAIL ilv rdata%0d got %h exp %h", i, src_data[i] ? data_rdata : inst_rdata, vals[i]); end
            tick();
        end
        idle_inputs();
    endtask

    // A stray response must leave the count at zero: exactly four more
    // accepts then fill the FIFO
    task automatic test_stray();
        m_data_ok = 1'b1; m_rdata = 32'h5A5A5A5A;
        #1;
        checks++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin errors++; $display("[TB] FAIL stray data_ok got %b exp 00", {inst_data_ok, data_data_ok}); end
        tick();
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            data_req = 1'b1; m_addr_ok = 1'b1;
            #1;
            checks++; if (data_addr_ok !== 1'b1) begin errors++; $display("[TB] FAIL stray fill%0d got %b exp 1", i, data_addr_ok); end
            tick();
        end
        #1;
        checks++; if (m_req !== 1'b0) begin errors++; $display("[TB] FAIL stray count got m_req=%b exp 0", m_req); end
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            m_data_ok = 1'b1;
            #1;
            checks++; if (data_data_ok !== 1'b1) begin errors++; $display("[TB] FAIL stray drain%0d got %b exp 1", i, data_data_ok); end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 2; i++) begin
            inst_req = 1'b1; m_addr_ok = 1'b1;
            #1;
            checks++; if (inst_addr_ok !== 1'b1) begin errors++; $display("[TB] FAIL rstmid fill%0d got %b exp 1", i, inst_addr_ok); end
            tick();
        end
        aresetn = 1'b0;
        #1;
        checks++; if (m_req !== 1'b0 || inst_addr_ok !== 1'b0) begin errors++; $display("[TB] FAIL rstmid during got %b/%b exp 0/0", m_req, inst_addr_ok); end
        tick();
        aresetn = 1'b1;
        idle_inputs();
        m_data_ok = 1'b1;
        #1;
        checks++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin errors++; $display("[TB] FAIL rstmid late got %b exp 00", {inst_data_ok, data_data_ok}); end
        tick();
        idle_inputs();
        inst_req = 1'b1; data_req = 1'b1; m_addr_ok = 1'b1;
        #1;
        checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b01) begin errors++; $display("[TB] FAIL rstmid next got %b exp 01", {inst_addr_ok, data_addr_ok}); end
        tick();
        idle_inputs();
        m_data_ok = 1'b1; m_rdata = 32'h0BADCAFE;
        #1;
        checks++; if ({inst_data_ok, data_data_ok} !== 2'b01 || data_rdata !== 32'h0BADCAFE) begin errors++; $display("[TB] FAIL rstmid resp got %b/%h exp 01/0badcafe", {inst_data_ok, data_data_ok}, data_rdata); end
        tick();
        idle_inputs();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_inst_read();
        test_tie_priority();
        test_tie_sequence();
        test_fifo_full();
        test_interleaved();
        test_stray();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
